// File: rtl/sm_mem_arbiter_if.sv
// Bus bundle for sm_mem_arbiter: fetch port, data port and the shared
// single-port memory. The arbiter uses the slave view; requesters and memory use master.
interface sm_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        m_en;
  logic        m_we;
  logic [6:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/sm_mem_arbiter.sv
// Shares one single-port 128x16 synchronous memory between a 32-bit fetch
// port (two halfword reads) and a halfword load/store port, round-robin on ties.
module sm_mem_arbiter (
  input  logic              clk,
  input  logic              rst,
  sm_mem_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    I_LO  = 3'd1,
    I_HI  = 3'd2,
    I_FIN = 3'd3,
    D_RD  = 3'd4,
    D_FIN = 3'd5,
    D_WR  = 3'd6
  } state_t;

  state_t      state, stateNext;
  logic        lastGrantData;   // 1: data port was served last
  logic        grantI, grantD;
  logic [5:0]  iAddrQ;
  logic [6:0]  dAddrQ;
  logic [15:0] dWdataQ;
  logic [15:0] loQ;
  logic [31:0] iRdataQ, dRdataQ;

  logic        mEn, mWe, iAck, dAck, loadFin;
  logic [6:0]  mAddr;
  logic [15:0] mWdata;
  logic [31:0] dLoadExt;

  // Upper address bits are don't-care: addresses wrap within the memory.
  logic unusedAddrBits;
  assign unusedAddrBits = &{1'b0, bus.i_addr[31:6], bus.d_addr[31:7]};

  assign dLoadExt = {{16{bus.m_rdata[15]}}, bus.m_rdata};

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    stateNext = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    mEn       = 1'b0;
    mWe       = 1'b0;
    mAddr     = '0;
    mWdata    = '0;
    iAck      = 1'b0;
    dAck      = 1'b0;

    case (state)
      IDLE: begin
        grantI = bus.i_req && (!bus.d_req || lastGrantData);
        grantD = bus.d_req && !grantI;
        if (grantI)      stateNext = I_LO;
        else if (grantD) stateNext = bus.d_we ? D_WR : D_RD;
      end
      I_LO: begin
        mEn       = 1'b1;
        mAddr     = {iAddrQ, 1'b0};
        stateNext = I_HI;
      end
      I_HI: begin
        mEn       = 1'b1;
        mAddr     = {iAddrQ, 1'b1};
        stateNext = I_FIN;
      end
      I_FIN: begin
        iAck      = 1'b1;
        stateNext = IDLE;
      end
      D_RD: begin
        mEn       = 1'b1;
        mAddr     = dAddrQ;
        stateNext = D_FIN;
      end
      D_FIN: begin
        dAck      = 1'b1;
        stateNext = IDLE;
      end
      D_WR: begin
        mEn       = 1'b1;
        mWe       = 1'b1;
        mAddr     = dAddrQ;
        mWdata    = dWdataQ;
        dAck      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    // Reset must suppress a write or ack in the very cycle it is asserted.
    if (rst) begin
      mEn    = 1'b0;
      mWe    = 1'b0;
      mAddr  = '0;
      mWdata = '0;
      iAck   = 1'b0;
      dAck   = 1'b0;
    end
  end

  assign loadFin = (state == D_FIN) && !rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lastGrantData <= 1'b0;
      iAddrQ        <= '0;
      dAddrQ        <= '0;
      dWdataQ       <= '0;
      loQ           <= '0;
      iRdataQ       <= '0;
      dRdataQ       <= '0;
    end else begin
      state <= stateNext;
      if (grantI) begin
        iAddrQ        <= bus.i_addr[5:0];
        lastGrantData <= 1'b0;
      end
      if (grantD) begin
        dAddrQ        <= bus.d_addr[6:0];
        dWdataQ       <= bus.d_wdata;
        lastGrantData <= 1'b1;
      end
      if (state == I_HI)  loQ     <= bus.m_rdata;
      if (state == I_FIN) iRdataQ <= {bus.m_rdata, loQ};
      if (state == D_FIN) dRdataQ <= dLoadExt;
    end
  end

  assign bus.m_en    = mEn;
  assign bus.m_we    = mWe;
  assign bus.m_addr  = mAddr;
  assign bus.m_wdata = mWdata;
  assign bus.i_ack   = iAck;
  assign bus.d_ack   = dAck;
  assign bus.i_rdata = iAck ? {bus.m_rdata, loQ} : iRdataQ;
  assign bus.d_rdata = loadFin ? dLoadExt : dRdataQ;
  assign bus.busy    = (state != IDLE) && !rst;

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Directed bench for sm_mem_arbiter: vector table for single transactions,
// hand sequences for round-robin, reset abort and early request drop.
module tb_sm_mem_arbiter;

  logic clk;
  logic rst;
  sm_mem_arbiter_if bus();

  sm_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: synchronous read, write on m_en&m_we, backdoor preload port.
  logic [15:0] mem [128];
  logic        preloadEn;
  logic [6:0]  preloadAddr;
  logic [15:0] preloadData;

  always @(posedge clk) begin
    if (preloadEn) mem[preloadAddr] <= preloadData;
    else if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
      else          bus.m_rdata    <= mem[bus.m_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.i_ack && bus.d_ack)                      viol++;
      if (bus.m_we && !bus.m_en)                       viol++;
      if (!bus.busy && (bus.m_en || bus.i_ack || bus.d_ack)) viol++;
    end
  end

  typedef struct {
    bit          isFetch;
    bit          we;
    logic [31:0] addr;
    logic [15:0] wdata;
    int          expLat;
    logic [31:0] expData;   // port rdata at ack (held value for stores)
    logic [6:0]  expMAddr;  // first memory address issued
  } vec_t;

  task automatic preload(input logic [6:0] a, input logic [15:0] d);
    preloadEn   = 1'b1;
    preloadAddr = a;
    preloadData = d;
    @(negedge clk);
    preloadEn   = 1'b0;
  endtask

  // Starts at a negedge with the DUT in IDLE; ends at the following IDLE negedge.
  task automatic runTxn(input vec_t v, input int idx);
    int          lat;
    logic [31:0] rd;
    logic        rightPort;
    lat = -1;
    rd = '0;
    rightPort = 1'b0;
    if (v.isFetch) begin
      bus.i_req  = 1'b1;
      bus.i_addr = v.addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check($sformatf("v%0d_maddr0", idx), 32'(bus.m_addr), 32'(v.expMAddr));
        check($sformatf("v%0d_mwe", idx), 32'(bus.m_we), 32'(v.we && !v.isFetch));
        if (!v.isFetch && v.we)
          check($sformatf("v%0d_mwdata", idx), 32'(bus.m_wdata), 32'(v.wdata));
      end
      if (c == 2 && v.isFetch)
        check($sformatf("v%0d_maddr1", idx), 32'(bus.m_addr), 32'(v.expMAddr) + 32'd1);
      if (bus.i_ack || bus.d_ack) begin
        lat       = c;
        rightPort = v.isFetch ? bus.i_ack : bus.d_ack;
        rd        = v.isFetch ? bus.i_rdata : bus.d_rdata;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.expLat));
    check($sformatf("v%0d_ackport", idx), 32'(rightPort), 32'd1);
    check($sformatf("v%0d_rdata", idx), rd, v.expData);
    @(negedge clk);
    check($sformatf("v%0d_idle_busy", idx), 32'(bus.busy), 32'd0);
    check($sformatf("v%0d_rdata_held", idx),
          v.isFetch ? bus.i_rdata : bus.d_rdata, v.expData);
  endtask

  vec_t vecs [9];
  int   dAckCyc [$];
  int   iAckCyc [$];
  int   idleCyc [$];
  int   expD [2] = '{2, 9};
  int   expI [2] = '{6, 13};
  int   expIdle [4] = '{3, 7, 10, 14};
  logic ackSeen;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'd5,    16'h0000, 3, 32'hABCD1234, 7'd10};
    vecs[1] = '{1'b0, 1'b1, 32'h85,   16'h8001, 1, 32'h00000000, 7'd5};
    vecs[2] = '{1'b0, 1'b0, 32'd5,    16'h0000, 2, 32'hFFFF8001, 7'd5};
    vecs[3] = '{1'b0, 1'b0, 32'd3,    16'h0000, 2, 32'h00007FFF, 7'd3};
    vecs[4] = '{1'b0, 1'b1, 32'h80,   16'h1357, 1, 32'h00007FFF, 7'd0};
    vecs[5] = '{1'b0, 1'b0, 32'd0,    16'h0000, 2, 32'h00001357, 7'd0};
    vecs[6] = '{1'b1, 1'b0, 32'h41,   16'h0000, 3, 32'h7FFF2222, 7'd2};
    vecs[7] = '{1'b0, 1'b1, 32'h0B,   16'h0F0F, 1, 32'h00001357, 7'd11};
    vecs[8] = '{1'b1, 1'b0, 32'd5,    16'h0000, 3, 32'h0F0F1234, 7'd10};

    rst         = 1'b1;
    preloadEn   = 1'b0;
    preloadAddr = '0;
    preloadData = '0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    @(negedge clk);
    check("reset_ctrl", 32'({bus.i_ack, bus.d_ack, bus.busy, bus.m_en, bus.m_we}), 32'd0);
    check("reset_maddr_wdata", {9'd0, bus.m_addr, bus.m_wdata}, 32'd0);
    check("reset_irdata", bus.i_rdata, 32'd0);
    check("reset_drdata", bus.d_rdata, 32'd0);

    preload(7'd10, 16'h1234);
    preload(7'd11, 16'hABCD);
    preload(7'd3,  16'h7FFF);
    preload(7'd2,  16'h2222);
    preload(7'd20, 16'h1111);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) runTxn(vecs[i], i);

    // Both requesters held from reset release: data wins first, then alternate.
    rst         = 1'b1;
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'd5;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'd3;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.d_ack) begin
        dAckCyc.push_back(k);
        if (dAckCyc.size() == 1) check("rr_first_load", bus.d_rdata, 32'h00007FFF);
      end
      if (bus.i_ack) iAckCyc.push_back(k);
      if (!bus.busy) idleCyc.push_back(k);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    check("rr_dack_count", 32'(dAckCyc.size()), 32'd2);
    check("rr_iack_count", 32'(iAckCyc.size()), 32'd2);
    check("rr_idle_count", 32'(idleCyc.size()), 32'd4);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("rr_dack_cyc%0d", j), 32'(dAckCyc.size() > j ? dAckCyc[j] : -1), 32'(expD[j]));
      check($sformatf("rr_iack_cyc%0d", j), 32'(iAckCyc.size() > j ? iAckCyc[j] : -1), 32'(expI[j]));
    end
    for (int j = 0; j < 4; j++)
      check($sformatf("rr_idle_cyc%0d", j), 32'(idleCyc.size() > j ? idleCyc[j] : -1), 32'(expIdle[j]));

    // Reset asserted during the D_WR cycle: no write, no ack.
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'd20;
    bus.d_wdata = 16'hBEEF;
    @(negedge clk);
    check("rstwr_state_dwr", 32'({bus.busy, bus.m_we}), 32'b11);
    rst = 1'b1;
    #1;
    check("rstwr_mwe", 32'({bus.m_en, bus.m_we}), 32'd0);
    check("rstwr_dack", 32'(bus.d_ack), 32'd0);
    bus.d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ackSeen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.d_ack || bus.i_ack) ackSeen = 1'b1;
      if (k == 0) check("rstwr_idle", 32'(bus.busy), 32'd0);
    end
    check("rstwr_no_ack", 32'(ackSeen), 32'd0);
    check("rstwr_mem_unchanged", 32'(mem[20]), 32'h1111);

    // d_req dropped in D_RD and address changed: the latched request completes.
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h85;
    @(negedge clk);
    check("drop_drd_maddr", 32'(bus.m_addr), 32'd5);
    bus.d_req  = 1'b0;
    bus.d_addr = 32'd3;
    @(negedge clk);
    check("drop_dack", 32'(bus.d_ack), 32'd1);
    check("drop_drdata", bus.d_rdata, 32'hFFFF8001);
    @(negedge clk);
    check("drop_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("drop_stays_idle", 32'({bus.busy, bus.d_ack}), 32'd0);

    check("invariants", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_mem_arbiter.md
SM_MEM_ARBITER -- requirements
Module: sm_mem_arbiter

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 i_req  in  1  instruction-fetch request; held high until i_ack.
REQ-004 i_addr  in  32  fetch word address; bits [5:0] used.
REQ-005 i_ack  out  1  one-cycle pulse: fetch done, i_rdata valid.
REQ-006 i_rdata  out  32  fetched word {hi half, lo half}; held until next fetch ack.
REQ-007 d_req  in  1  data request; held high until d_ack.
REQ-008 d_we  in  1  1 = halfword store (sh), 0 = halfword load (lh).
REQ-009 d_addr  in  32  data halfword address, already base+offset; bits [6:0] used.
REQ-010 d_wdata  in  16  store data.
REQ-011 d_ack  out  1  one-cycle pulse: data access done.
REQ-012 d_rdata  out  32  sign-extended load halfword; held until next load ack.
REQ-013 m_en  out  1  memory access enable.
REQ-014 m_we  out  1  memory write enable; only high with m_en.
REQ-015 m_addr  out  7  memory halfword address.
REQ-016 m_wdata  out  16  memory write data.
REQ-017 m_rdata  in  16  memory read data, valid one cycle after m_en with m_we=0.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 Block shares one single-port 128x16 synchronous memory between fetch and data ports.
REQ-020 FSM states: IDLE, I_LO, I_HI, I_FIN, D_RD, D_FIN, D_WR.
REQ-021 IDLE: no requests -> stay; only i_req -> I_LO; only d_req -> D_RD (d_we=0) or D_WR (d_we=1).
REQ-022 IDLE, both requests: round-robin on 1-bit last_grant; grant the port not served last; last_grant updates on grant.
REQ-023 Address, d_we and d_wdata latched on the IDLE->grant edge; later input changes are ignored until return to IDLE.
REQ-024 I_LO: m_en=1, m_we=0, m_addr={i_addr[5:0],0}; -> I_HI.
REQ-025 I_HI: capture m_rdata as lo; m_en=1, m_addr={i_addr[5:0],1}; -> I_FIN.
REQ-026 I_FIN: i_rdata={m_rdata,lo}, i_ack=1, m_en=0; -> IDLE.
REQ-027 D_RD: m_en=1, m_we=0, m_addr=d_addr[6:0]; -> D_FIN.
REQ-028 D_FIN: d_rdata={{16{m_rdata[15]}},m_rdata}, d_ack=1; -> IDLE.
REQ-029 D_WR: m_en=1, m_we=1, m_addr=d_addr[6:0], m_wdata=d_wdata, d_ack=1; -> IDLE.
REQ-030 Latency from req sampled in IDLE at cycle T: fetch ack T+3, load ack T+2, store ack T+1.
REQ-031 Every transaction returns to IDLE for exactly one cycle; no back-to-back grant without IDLE.
REQ-032 Requester deasserting req mid-transaction: transaction completes, ack still pulses, store still written.
REQ-033 Address bits above used range are ignored (wrap): d_addr 0x80 accesses halfword 0.
REQ-034 m_en=0, m_we=0 in IDLE, I_FIN, D_FIN; never two memory accesses in one cycle.
REQ-035 i_ack and d_ack are never high in the same cycle.

Reset
REQ-036 rst high: next state IDLE, last_grant=fetch (data wins first tie), i_ack=d_ack=0, busy=0.
REQ-037 Reset values: i_rdata=0, d_rdata=0, m_en=0, m_we=0, m_addr=0, m_wdata=0, latches cleared.
REQ-038 Reset mid-transaction aborts it: no ack pulses, no write issued in or after the reset cycle.

Verification
REQ-039 Preload mem[10]=0x1234, mem[11]=0xABCD; i_req, i_addr=5 at T -> m_addr 10 at T+1, 11 at T+2; i_ack at T+3, i_rdata=0xABCD1234.
REQ-040 d_req, d_we=1, d_addr=0x85, d_wdata=0x8001 -> m_we=1, m_addr=5 at T+1, d_ack at T+1; then load addr 5 -> d_rdata=0xFFFF8001 at T+2.
REQ-041 i_req and d_req both held high from reset release -> grants D, I, D, I alternate; ack order d,i,d,i; one IDLE cycle between each.
REQ-042 rst asserted during D_WR -> no m_we pulse in that cycle, d_ack=0, FSM in IDLE next cycle, memory unchanged.
REQ-043 d_req dropped in D_RD cycle -> d_ack still pulses at T+2 with correct sign-extended data; FSM back to IDLE.
REQ-044 Load mem[3]=0x7FFF -> d_rdata=0x00007FFF; busy low only in IDLE throughout all scenarios.
